// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit add/subtract unit among NUM_REQ requesters.
// Define ADDARB_OVF_EN to generate the registered signed-overflow flag on resp_ovf.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_ovf
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            sub_q, sub_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic [31:0]     sel_a, sel_b;
  logic            sel_sub;
  logic [31:0]     b_eff, sum;

  // Search starts at rr_ptr so the last-served requester has lowest priority.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_sub   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_found && (grant_idx == ID_W'(i));
      if (grant_idx == ID_W'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  // The single shared adder; subtraction adds the two's complement of b.
  assign b_eff = sub_q ? (~b_q + 32'd1) : b_q;
  assign sum   = a_q + b_eff;

`ifdef ADDARB_OVF_EN
  logic resp_ovf_q, resp_ovf_d;
  logic ovf_calc;

  assign ovf_calc = sub_q ? ((a_q[31] != b_q[31]) && (sum[31] != a_q[31]))
                          : ((a_q[31] == b_q[31]) && (sum[31] != a_q[31]));
  assign resp_ovf = resp_ovf_q;
`else
  assign resp_ovf = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
`ifdef ADDARB_OVF_EN
    resp_ovf_d   = resp_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          sub_d   = sel_sub;
          gid_d   = grant_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        resp_data_d  = sum;
        resp_id_d    = gid_q;
`ifdef ADDARB_OVF_EN
        resp_ovf_d   = ovf_calc;
`endif
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (gid_q == ID_W'(NUM_REQ-1)) ? '0 : gid_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers are reset too, so no X can reach the adder after reset.
  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      gid_q        <= '0;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
`ifdef ADDARB_OVF_EN
      resp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      gid_q        <= gid_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
`ifdef ADDARB_OVF_EN
      resp_ovf_q   <= resp_ovf_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: vector table plus hand-written multi-cycle sequences,
// with a queue scoreboard filled on accept and drained on each response handshake.
module tb_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_sub;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic                  resp_valid, resp_ready, resp_ovf;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            ovf;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] data;
    logic        ovf;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] exp_data_r[NUM_REQ];
  logic        exp_ovf_r[NUM_REQ];
  logic        acc_fired, resp_fired, valid_s;
  int          acc_idx;
  logic [NUM_REQ-1:0] ready_s;
  logic [31:0] data_s;
  logic [ID_W-1:0] id_s;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = sub ? a - b : a + b;
`ifdef ADDARB_OVF_EN
    e.ovf  = sub ? ((a[31] != b[31]) && (e.data[31] != a[31]))
                 : ((a[31] == b[31]) && (e.data[31] != a[31]));
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] data, input logic ovf);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i]        = sub;
    exp_data_r[i]     = data;
`ifdef ADDARB_OVF_EN
    exp_ovf_r[i]      = ovf;
`else
    exp_ovf_r[i]      = 1'b0;
`endif
  endtask

  // Samples 1 time unit after the falling edge, records handshakes due at the next rising edge.
  task automatic tick();
    exp_t e;
    #1;
    acc_fired  = 1'b0;
    resp_fired = 1'b0;
    ready_s    = req_ready;
    valid_s    = resp_valid;
    data_s     = resp_data;
    id_s       = resp_id;
    check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (req_ready != '0) begin
      acc_fired = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) acc_idx = i;
      e.id   = ID_W'(acc_idx);
      e.data = exp_data_r[acc_idx];
      e.ovf  = exp_ovf_r[acc_idx];
      sb.push_back(e);
    end
    if (resp_valid && resp_ready) begin
      resp_fired = 1'b1;
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_acc(input string name);
    int n = 0;
    do begin tick(); n++; end while (!acc_fired && n < 20);
    check(name, 32'(acc_fired), 32'd1);
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    do begin tick(); n++; end while (!resp_fired && n < 20);
    check(name, 32'(resp_fired), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin tick(); n++; end while (!valid_s && n < 20);
    check(name, 32'(valid_s), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid  = '0;
    resp_ready = 1'b1;
    do begin tick(); n++; end while (!(sb.size() == 0 && !valid_s) && n < 20);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    int n_acc;

    vecs[0] = '{0, 32'd3,          32'd10,         1'b1, 32'hFFFF_FFF9, 1'b0};
    vecs[1] = '{1, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000, 1'b1};
    vecs[2] = '{2, 32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{3, 32'd0,          32'h8000_0000,  1'b1, 32'h8000_0000, 1'b1};
    vecs[4] = '{0, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{2, 32'd100,        32'd100,        1'b1, 32'h0000_0000, 1'b0};
    vecs[7] = '{3, 32'h1234_5678,  32'h8765_4321,  1'b0, 32'h9999_9999, 1'b0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin exp_data_r[i] = '0; exp_ovf_r[i] = 1'b0; end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_ovf", 32'(resp_ovf), 32'd0);
    rst = 1'b0;

    // Single request from requester 2 with exact latency checks.
    set_op(2, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0);
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    tick();
    check("t1_grant", 32'(ready_s), 32'h4);
    req_valid = '0;
    req_a[64 +: 32] = 32'hDEAD_BEEF;
    tick();
    check("t1_calc_ready", 32'(ready_s), 32'd0);
    check("t1_calc_valid", 32'(valid_s), 32'd0);
    tick();
    check("t1_resp_valid", 32'(valid_s), 32'd1);
    check("t1_resp_fired", 32'(resp_fired), 32'd1);
    tick();
    check("t1_after_valid", 32'(valid_s), 32'd0);

    for (int v = 0; v < 8; v++) begin
      set_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].data, vecs[v].ovf);
      req_valid  = NUM_REQ'(1) << vecs[v].id;
      resp_ready = 1'b1;
      wait_acc("vec_accept");
      req_valid = '0;
      wait_resp("vec_resp");
    end

    // Round-robin fairness from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      ra = $urandom; rb = $urandom;
      e = model(i, ra, rb, i[0]);
      set_op(i, ra, rb, i[0], e.data, e.ovf);
    end
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    n_acc = 0;
    for (int n = 0; n < 100 && n_acc < 8; n++) begin
      tick();
      if (acc_fired) begin
        check("rr_order", 32'(acc_idx), 32'(n_acc % NUM_REQ));
        n_acc++;
        ra = $urandom; rb = $urandom;
        e = model(acc_idx, ra, rb, 1'b1);
        set_op(acc_idx, ra, rb, 1'b1, e.data, e.ovf);
      end
    end
    check("rr_count", 32'(n_acc), 32'd8);
    drain();

    // Backpressure: response held for 5 cycles while every requester waits.
    set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    wait_acc("bp_accept");
    check("bp_grant", 32'(acc_idx), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i != 1) begin
        e = model(i, 32'(i * 1000), 32'd17, 1'b0);
        set_op(i, 32'(i * 1000), 32'd17, 1'b0, e.data, e.ovf);
      end
    end
    req_valid = 4'hF;
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 32'(valid_s), 32'd1);
      check("bp_hold_data", data_s, 32'h2345_6789);
      check("bp_hold_id", 32'(id_s), 32'd1);
      check("bp_hold_ready", 32'(ready_s), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release", 32'(resp_fired), 32'd1);
    tick();
    check("bp_valid_clear", 32'(valid_s), 32'd0);
    check("bp_next_grant", 32'(acc_fired ? acc_idx : -1), 32'd2);
    req_valid = '0;
    drain();

    // Reset while a response is pending: no clock edge needed, pointer returns to 0.
    set_op(3, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0);
    req_valid  = 4'b1000;
    resp_ready = 1'b0;
    wait_acc("rr_accept3");
    req_valid = '0;
    wait_valid("rst_mid_valid");
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_resp_data", resp_data, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    set_op(1, 32'd40, 32'd2, 1'b0, 32'd42, 1'b0);
    set_op(3, 32'd9, 32'd9, 1'b0, 32'd18, 1'b0);
    req_valid  = 4'b1010;
    resp_ready = 1'b1;
    tick();
    check("rst_mid_next_grant", 32'(acc_fired ? acc_idx : -1), 32'd1);
    req_valid = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
